fifo_rd_streamer: RTL and testbench
===================================

# fifo_rd_streamer

Read-side companion to the team's dual-clock FIFO: lives entirely in the FIFO's read-clock domain, drives the FIFO pop interface (`rd_en`/`rd_data`/`empty`) and re-presents the data as a registered valid/ready stream with burst framing. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer. It sustains one word per cycle under continuous `m_ready`, and never pops an empty FIFO. It also provides a flush state machine that drains and discards FIFO contents.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data
- `BURST_LEN`, 4, words per burst; `m_last` marks the final word; legal range 1..256

- `rd_clk`  in  1  read-domain clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  1 = popping permitted; 0 = no new pops (in-flight and buffered words still delivered)
- `flush`  in  1  single-cycle request: discard buffer and drain FIFO
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_en`  out  1  FIFO pop strobe
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop
- `m_valid`  out  1  stream word valid
- `m_ready`  in  1  downstream accepts word
- `m_data`  out  DATA_WIDTH  stream data
- `m_last`  out  1  last word of burst (qualified by `m_valid`)
- `flush_busy`  out  1  flush in progress

## Operation
- States: RUN, DRAIN, SETTLE. Reset → RUN.
- RUN:
  - `hs` = `m_valid & m_ready`.
  - `inflight` = registered `fifo_rd_en` of the previous cycle.
  - `fifo_rd_en` = `enable & !fifo_empty & (buf_cnt + inflight - hs) < 2`. Combinational, so every strobe is a real pop.
  - Landing word (`inflight`=1) is written to the buffer tail. The buffer is 2 entries FIFO-ordered. `m_data` is the head.
  - `m_valid` = `buf_cnt != 0`.
- Burst counter `beat` (width clog2(BURST_LEN), min 1 bit):
  - Increments on `hs`, wrapping to 0 after BURST_LEN-1.
  - `m_last` = `m_valid & (beat == BURST_LEN-1)`. BURST_LEN=1 → `m_last` = `m_valid`.
- `flush` in RUN:
  - Next cycle enter DRAIN.
  - Buffer cleared, `beat` cleared.
  - Any in-flight word is discarded on landing.
  - `hs` is ignored in the flush cycle: the word is not delivered.
- DRAIN:
  - `m_valid`=0.
  - `fifo_rd_en` = `!fifo_empty`, ignoring `enable`. Returned words are discarded.
  - On `fifo_empty`=1 → SETTLE.
- SETTLE:
  - One cycle, no pop. Discards the last landing word.
  - → RUN.
- `flush_busy` = state != RUN. `flush` while busy is ignored.
- `rst_n`=0 at any time, including mid-burst or mid-flush:
  - Next edge forces RUN with `buf_cnt`=0, `inflight`=0, `beat`=0.
  - A word landing after reset is discarded.
- Backpressure: buffer full with `m_ready`=0 → no pop. `m_data`/`m_last` remain stable while `m_valid & !m_ready`.

## Timing
- Reset values: `fifo_rd_en`=0 (combinational, forced 0 while `rst_n`=0), `m_valid`=0, `m_data`=0, `m_last`=0, `flush_busy`=0.
- Latency: `fifo_empty` falls in cycle N (`enable`=1, buffer empty) → `fifo_rd_en`=1 in N, word lands in N+1, `m_valid`=1 in N+2.
- Throughput: 1 word/cycle when `m_ready` is held 1 and the FIFO is non-empty.
- Max outstanding words (buffered + in-flight) = 2. Never overflows.
- `m_ready` deasserted in cycle K → at most 1 further pop is issued; buffer fills to 2 by K+1.
- Flush duration = FIFO occupancy + 2 cycles (DRAIN entry + SETTLE); minimum 2 cycles with an empty FIFO.

## Configuration
- `FIFO_RD_STREAMER_STATS_EN` defined:
  - Adds output `pop_count` (16 bits), counting delivered words (`hs`), saturating at 16'hFFFF.
  - Cleared by reset and on flush entry. Words discarded by flush are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `fifo_empty`=0 → `fifo_rd_en`=0, `m_valid`=0, `flush_busy`=0 throughout.
- Streaming: FIFO preloaded with 0x10..0x17, `m_ready`=1, BURST_LEN=4 → first `m_valid` 2 cycles after first pop, then 8 consecutive words 0x10..0x17, `m_last` on 0x13 and 0x17, no gaps.
- Backpressure: 6 words queued, `m_ready` toggling 1,0,0,1,… → all 6 words delivered in order, no duplicates, never more than 2 outstanding. `m_data` stable while stalled.
- Empty boundary: a single word 0xA5 written, `m_ready`=1 → exactly one pop, one `m_valid` beat with 0xA5, `fifo_rd_en` never asserted while `fifo_empty`=1.
- Flush: 5 words in FIFO, 2 buffered, `m_ready`=0, `flush` pulsed → `flush_busy`=1 for FIFO-occupancy+2 cycles, no `m_valid`, FIFO empty afterwards. Next word 0x3C is delivered with `beat`=0.
- Reset mid-burst: reset after 2 of 4 words delivered, then 4 new words → `m_last` on the 4th new word. With `FIFO_RD_STREAMER_STATS_EN`, `pop_count`=4.

Source files
------------

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: pops a registered-read FIFO into a 2-entry valid/ready stream buffer with burst framing and flush.
// Optional pop_count statistics output enabled by FIFO_RD_STREAMER_STATS_EN.
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  flush_busy
`ifdef FIFO_RD_STREAMER_STATS_EN
  ,
  output logic [15:0]           pop_count
`endif
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
  typedef enum logic [1:0] {RUN, DRAIN, SETTLE} state_t;
  state_t state, state_nx;
  logic inflight, hs, go;
  logic [1:0] buf_cnt, wpos;
  logic [2:0] occ;
  logic [DATA_WIDTH-1:0] b0, b1;
  logic [BW-1:0] beat;
  assign go = flush & (state == RUN);
  assign hs = m_valid & m_ready & !go;
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, hs};
  assign wpos = buf_cnt - {1'b0, hs};
  assign m_valid = buf_cnt != 2'd0;
  assign m_data = b0;
  assign m_last = m_valid & (beat == LAST);
  always_ff @(posedge rd_clk)
    state <= !rst_n ? RUN : state_nx;
  always_comb
    state_nx = state == RUN ? (go ? DRAIN : RUN) :
               state == DRAIN ? (fifo_empty ? SETTLE : DRAIN) : RUN;
  // No pop in the flush cycle, so drain time tracks FIFO occupancy exactly.
  always_comb begin
    fifo_rd_en = rst_n & !fifo_empty &
                 (state == DRAIN | (state == RUN & enable & !go & occ < 3'd2));
    flush_busy = state != RUN;
  end
  always_ff @(posedge rd_clk) begin
    inflight <= rst_n & fifo_rd_en;
    if (!rst_n) begin
      buf_cnt <= '0;
      beat <= '0;
      b0 <= '0;
      b1 <= '0;
    end else if (go) begin
      buf_cnt <= '0;
      beat <= '0;
    end else if (state == RUN) begin
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, hs};
      b0 <= inflight && wpos == 2'd0 ? fifo_rd_data : hs ? b1 : b0;
      b1 <= inflight && wpos == 2'd1 ? fifo_rd_data : b1;
      beat <= !hs ? beat : beat == LAST ? '0 : beat + 1'b1;
    end
  end
`ifdef FIFO_RD_STREAMER_STATS_EN
  always_ff @(posedge rd_clk)
    pop_count <= !rst_n || go ? 16'd0 :
                 hs && pop_count != 16'hFFFF ? pop_count + 16'd1 : pop_count;
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed bench with a registered-read FIFO model feeding fifo_rd_streamer.
module tb_fifo_rd_streamer;
  logic rd_clk = 1'b0;
  logic rst_n, enable, flush, fifo_empty, fifo_rd_en, m_valid, m_ready, m_last, flush_busy;
  logic [7:0] fifo_rd_data = 8'h00;
  logic [7:0] m_data;
`ifdef FIFO_RD_STREAMER_STATS_EN
  logic [15:0] pop_count;
`endif
  logic [7:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  int checks = 0;
  int failures = 0;

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (wp == rp);
  always @(posedge rd_clk)
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end

  fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .flush_busy(flush_busy)
`ifdef FIFO_RD_STREAMER_STATS_EN
    , .pop_count(pop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp[7:0]] = d;
    wp++;
  endtask

  // A pop against an empty FIFO is never legal, whatever the test step.
  always @(negedge rd_clk)
    if (fifo_empty) begin
      checks++;
      assert (fifo_rd_en === 1'b0) else begin
        failures++;
        $error("FAIL pop_on_empty observed=%b expected=0", fifo_rd_en);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, outst, pops, beats, busy;
    logic stalled;
    logic [7:0] prev;
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(16 + i));
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", flush_busy, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("first_pop", fifo_rd_en, 1);
    chk("lat_n_valid", m_valid, 0);
    cyc();
    chk("lat_n1_valid", m_valid, 0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", m_valid, 1);
      chk("stream_data", m_data, 32'(16 + i));
      chk("stream_last", m_last, 32'(i % 4 == 3));
      cyc();
    end
    chk("stream_done", m_valid, 0);

    got = 0; outst = 0; stalled = 1'b0; prev = 8'h00;
    for (int i = 0; i < 6; i++) push(8'(32 + i));
    for (int c = 0; c < 40 && got < 6; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (stalled) begin
        chk("bp_stable_valid", m_valid, 1);
        chk("bp_stable_data", m_data, prev);
      end
      if (m_valid && m_ready) begin
        chk("bp_data", m_data, 32'(32 + got));
        got++;
      end
      outst = outst + int'(fifo_rd_en) - int'(m_valid && m_ready);
      chk("bp_outstanding", outst <= 2, 1);
      stalled = m_valid && !m_ready;
      prev = m_data;
      cyc();
    end
    chk("bp_count", got, 6);
    m_ready = 1'b1;

    pops = 0; beats = 0;
    push(8'hA5);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_rd_en) pops++;
      if (m_valid && m_ready) begin
        beats++;
        chk("one_data", m_data, 32'hA5);
        chk("one_last", m_last, 0);
      end
      cyc();
    end
    chk("one_pops", pops, 1);
    chk("one_beats", beats, 1);

    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(8'(48 + i));
    repeat (6) cyc();
    chk("fl_pre_valid", m_valid, 1);
    chk("fl_pre_data", m_data, 32'h30);
    chk("fl_pre_last", m_last, 1);
    chk("fl_pre_occ", wp - rp, 5);
    flush = 1'b1;
    #1;
    chk("fl_cycle_busy", flush_busy, 0);
    cyc();
    flush = 1'b0;
    busy = 0;
    for (int c = 0; c < 20 && flush_busy; c++) begin
      chk("fl_no_valid", m_valid, 0);
      busy++;
      cyc();
    end
    chk("fl_busy_len", busy, 7);
    chk("fl_fifo_empty", fifo_empty, 1);
    chk("fl_post_valid", m_valid, 0);
`ifdef FIFO_RD_STREAMER_STATS_EN
    chk("fl_pop_count", pop_count, 0);
`endif
    m_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 4; i++) push(8'(60 + i));
    for (int c = 0; c < 15 && got < 4; c++) begin
      #1;
      if (m_valid) begin
        chk("fl_next_data", m_data, 32'(60 + got));
        chk("fl_next_last", m_last, 32'(got == 3));
        got++;
      end
      cyc();
    end
    chk("fl_next_count", got, 4);

    got = 0;
    for (int i = 0; i < 4; i++) push(8'(64 + i));
    for (int c = 0; c < 15; c++) begin
      #1;
      if (m_valid) begin
        chk("mid_data", m_data, 32'(64 + got));
        got++;
        if (got == 2) break;
      end
      cyc();
    end
    cyc();
    rst_n = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    cyc();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", flush_busy, 0);
    wp = rp;
    rst_n = 1'b1;
    m_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 4; i++) push(8'(80 + i));
    for (int c = 0; c < 15 && got < 4; c++) begin
      #1;
      if (m_valid) begin
        chk("new_data", m_data, 32'(80 + got));
        chk("new_last", m_last, 32'(got == 3));
        got++;
      end
      cyc();
    end
    chk("new_count", got, 4);
`ifdef FIFO_RD_STREAMER_STATS_EN
    chk("new_pop_count", pop_count, 4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
